btn_debounce_pulse: RTL and testbench
=====================================

// Module: btn_debounce_pulse
// PURPOSE
// - Conditions raw pushbuttons into clean one-shot command pulses for the memory front-end.
// - Typical inputs are BTN_addr and BTN_write. Its btn_pulse outputs drive the memory
//   block's address-latch and write-enable inputs directly.
// - Per button: 2-FF synchroniser, debounce counter, registered stable level,
//   one-cycle press and release pulses.
// PARAMETERS
// - N_BTN           2          number of independent buttons
// - DEBOUNCE_CYCLES 1000000    cycles input must be stable before accepted (10 ms @ 100 MHz); >=2
// - CNT_W           20         debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
// - REPEAT_DELAY    50000000   cycles from press pulse to first repeat (AUTO_REPEAT_EN only)
// - REPEAT_PERIOD   10000000   cycles between repeat pulses (AUTO_REPEAT_EN only)
// - RPT_W           26         repeat counter width; 2**RPT_W > max(REPEAT_DELAY, REPEAT_PERIOD)
// PORTS
// - clk          in   1      system clock; all logic on posedge
// - initialise   in   1      synchronous active-high reset
// - btn_raw      in   N_BTN  asynchronous raw button inputs; 1 = pressed
// - btn_level    out  N_BTN  debounced stable level per button
// - btn_pulse    out  N_BTN  one-cycle pulse on accepted press (and on repeats, see CONFIGURATION)
// - btn_release  out  N_BTN  one-cycle pulse on accepted release
// BEHAVIOUR
// - Reset (initialise=1 at posedge): sync FFs, counters and btn_level/btn_pulse/btn_release all go to 0.
//   An in-progress count is discarded.
// - Per-button FSM: STABLE_LO -> CHK_HI -> STABLE_HI -> CHK_LO -> STABLE_LO.
// - STABLE_x: counter = 0. If synced input != stable level, go to CHK_x and set counter to 1.
// - CHK_x, synced input still differs:
//   - counter < DEBOUNCE_CYCLES-1: counter increments.
//   - counter == DEBOUNCE_CYCLES-1: level flips, counter clears, state -> STABLE of the new level.
// - CHK_x, synced input returns to the stable level: counter clears, state -> STABLE_x.
//   A glitch shorter than DEBOUNCE_CYCLES never reaches the outputs.
// - Latency: a clean edge on btn_raw appears on btn_level exactly DEBOUNCE_CYCLES+2 posedges after
//   the first posedge that samples it (2 sync + DEBOUNCE_CYCLES).
// - btn_pulse[i] = 1 only in the cycle where btn_level[i] goes 0->1.
// - btn_release[i] = 1 only in the cycle where btn_level[i] goes 1->0.
// - All outputs are registered; no combinational path from btn_raw.
// - Buttons are fully independent. Simultaneous presses give simultaneous pulses, with no priority.
// - Button held through reset: it is treated as a fresh press once initialise drops,
//   giving one pulse after DEBOUNCE_CYCLES+2 cycles.
// - Counter never wraps: it is bounded by DEBOUNCE_CYCLES-1 and cleared on every level flip.
// CONFIGURATION
// - Macro BTN_DEBOUNCE_AUTO_REPEAT_EN.
// - Defined: a per-button repeat counter runs while btn_level=1.
//   - First repeat btn_pulse fires REPEAT_DELAY cycles after the press pulse.
//   - Further repeats fire every REPEAT_PERIOD cycles while held.
//   - Counter clears on release, on reset, and in every non-STABLE_HI cycle.
//   - btn_release is unaffected.
// - Undefined: repeat logic and the REPEAT_* parameters are unused, with no repeat counters
//   synthesised. Exactly one btn_pulse per accepted press.
// TESTING (bench uses DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
// 1. initialise=1 for 2 cycles with btn_raw=2'b11 -> all outputs 0.
//    Release reset -> btn_pulse=2'b11 for exactly one cycle, 6 posedges later; btn_level=2'b11 after.
// 2. btn_raw[0] high for 3 cycles then low -> btn_level, btn_pulse, btn_release stay 0 (glitch rejected).
// 3. btn_raw[0] bouncing 1,0,1,1,0 then held 1 -> one btn_pulse[0], DEBOUNCE_CYCLES+2 cycles after the final rise.
// 4. Held press, then btn_raw[0]=0 held -> btn_release[0] one cycle, 6 posedges after the fall; btn_level[0]=0.
// 5. initialise asserted mid-CHK_HI (counter=2) -> counter and level 0 next cycle.
//    Re-press -> full 6-cycle latency again.
// 6. With BTN_DEBOUNCE_AUTO_REPEAT_EN, hold btn_raw[1] 30 cycles -> pulses at press P, P+10, P+13, P+16, ...
//    No pulse after release. Without the macro: single pulse at P.

Source files
------------

// File: rtl/btn_debounce_pulse.sv
// rtl/btn_debounce_pulse.sv - per-button synchroniser, debouncer and press/release pulse generator
// Optional auto-repeat of press pulses while held: define BTN_DEBOUNCE_AUTO_REPEAT_EN.
module btn_debounce_pulse #(
  parameter int N_BTN           = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000,
  parameter int RPT_W           = 26
) (
  input  logic             clk,
  input  logic             initialise,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [N_BTN-1:0] btn_release
);

  localparam logic [1:0] ST_STABLE_LO = 2'd0;
  localparam logic [1:0] ST_CHK_HI    = 2'd1;
  localparam logic [1:0] ST_STABLE_HI = 2'd2;
  localparam logic [1:0] ST_CHK_LO    = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Parameter sanity: a counter too narrow for the debounce window, or a window
  // below two cycles, would silently shorten the debounce; the block below only
  // elaborates for such an invalid configuration so it stands out in elaboration logs.
  if ((DEBOUNCE_CYCLES < 2) || (CNT_W < 1) || (CNT_W < 31 && (2 ** CNT_W) <= DEBOUNCE_CYCLES)
      || (REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1) || (RPT_W < 1)) begin : g_bad_config
    localparam bit CONFIG_ERROR = 1'b1;
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    logic             sync1_q;
    logic             sync2_q;
    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             press_q;
    logic             press_d;
    logic             rel_q;
    logic             rel_d;
    logic             edge_rise;
    logic             edge_fall;

    // Two-flop synchroniser for the asynchronous raw input
    always_ff @(posedge clk) begin
      if (initialise) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
      end else begin
        sync1_q <= btn_raw[i];
        sync2_q <= sync1_q;
      end
    end

    // Debounce FSM: a level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      case (state_q)
        ST_STABLE_LO: begin
          cnt_d = '0;
          if (sync2_q) begin
            state_d = ST_CHK_HI;
            cnt_d   = CNT_ONE;
          end
        end
        ST_CHK_HI: begin
          if (!sync2_q) begin
            state_d = ST_STABLE_LO;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_STABLE_HI;
            cnt_d   = '0;
            level_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_STABLE_HI: begin
          cnt_d = '0;
          if (!sync2_q) begin
            state_d = ST_CHK_LO;
            cnt_d   = CNT_ONE;
          end
        end
        ST_CHK_LO: begin
          if (sync2_q) begin
            state_d = ST_STABLE_HI;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_STABLE_LO;
            cnt_d   = '0;
            level_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = ST_STABLE_LO;
          cnt_d   = '0;
          level_d = 1'b0;
        end
      endcase
    end

    assign edge_rise = level_d & ~level_q;
    assign edge_fall = ~level_d & level_q;

`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
    localparam logic [RPT_W-1:0] RPT_ONE    = RPT_W'(1);
    localparam logic [RPT_W-1:0] RPT_D_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_P_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] rpt_q;
    logic [RPT_W-1:0] rpt_d;
    logic             rpt_phase_q;
    logic             rpt_phase_d;
    logic             rpt_fire;

    // Repeat timer: counts cycles spent continuously in STABLE_HI; phase 0 waits
    // for the initial delay, phase 1 produces the periodic repeats
    always_comb begin
      rpt_d       = '0;
      rpt_phase_d = 1'b0;
      rpt_fire    = 1'b0;
      if ((state_q == ST_STABLE_HI) && (state_d == ST_STABLE_HI)) begin
        rpt_phase_d = rpt_phase_q;
        if (!rpt_phase_q) begin
          if (rpt_q == RPT_D_LAST) begin
            rpt_fire    = 1'b1;
            rpt_d       = '0;
            rpt_phase_d = 1'b1;
          end else begin
            rpt_d = rpt_q + RPT_ONE;
          end
        end else begin
          if (rpt_q == RPT_P_LAST) begin
            rpt_fire = 1'b1;
            rpt_d    = '0;
          end else begin
            rpt_d = rpt_q + RPT_ONE;
          end
        end
      end
    end

    // Repeat timer state
    always_ff @(posedge clk) begin
      if (initialise) begin
        rpt_q       <= '0;
        rpt_phase_q <= 1'b0;
      end else begin
        rpt_q       <= rpt_d;
        rpt_phase_q <= rpt_phase_d;
      end
    end

    assign press_d = edge_rise | rpt_fire;
`else
    assign press_d = edge_rise;
`endif

    assign rel_d = edge_fall;

    // Debounce state, stable level and registered one-shot outputs
    always_ff @(posedge clk) begin
      if (initialise) begin
        state_q <= ST_STABLE_LO;
        cnt_q   <= '0;
        level_q <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        level_q <= level_d;
        press_q <= press_d;
        rel_q   <= rel_d;
      end
    end

    assign btn_level[i]   = level_q;
    assign btn_pulse[i]   = press_q;
    assign btn_release[i] = rel_q;
  end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// tb/tb_btn_debounce_pulse.sv - self-checking bench for btn_debounce_pulse
module tb_btn_debounce_pulse;
  localparam int NB = 2;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic          clk = 1'b0;
  logic          initialise;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_pulse;
  logic [NB-1:0] btn_release;

  always #5 clk = ~clk;

  btn_debounce_pulse #(
    .N_BTN(NB), .DEBOUNCE_CYCLES(DB), .CNT_W(3),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .RPT_W(5)
  ) dut (
    .clk(clk), .initialise(initialise), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_pulse(btn_pulse), .btn_release(btn_release)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b (level,pulse,release)", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // Reference model: a level change is accepted at an edge when the last DB
  // synchronised samples (raw samples 2..DB+1 edges old) all disagree with the level.
  bit [DB+1:0] hist [NB];
  bit [NB-1:0] m_lvl, m_pls, m_rel, m_sthi;
  int          m_run [NB];

  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      bit flip;
      bit new_lvl;
      bit now_hi;
      bit fire;
      if (initialise) begin
        hist[b]   = '0;
        m_lvl[b]  = 1'b0;
        m_pls[b]  = 1'b0;
        m_rel[b]  = 1'b0;
        m_sthi[b] = 1'b0;
        m_run[b]  = 0;
      end else begin
        hist[b] = {hist[b][DB:0], btn_raw[b]};
        flip = 1'b1;
        for (int k = 2; k < DB + 2; k++)
          if (hist[b][k] == m_lvl[b]) flip = 1'b0;
        new_lvl = m_lvl[b] ^ flip;
        now_hi  = new_lvl && (flip || hist[b][2]);
        if (now_hi && m_sthi[b]) m_run[b] = m_run[b] + 1;
        else m_run[b] = 0;
        fire = 1'b0;
`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
        fire = now_hi && (m_run[b] == RD || (m_run[b] > RD && (m_run[b] - RD) % RP == 0));
`endif
        m_pls[b]  = (flip && new_lvl) || fire;
        m_rel[b]  = flip && !new_lvl;
        m_lvl[b]  = new_lvl;
        m_sthi[b] = now_hi;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    check("model", {btn_level, btn_pulse, btn_release}, {m_lvl, m_pls, m_rel});
  endtask

  typedef struct {
    bit       init;
    bit [1:0] raw;
    bit [1:0] lvl;
    bit [1:0] pls;
    bit [1:0] rel;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit init, input bit [1:0] raw, input bit [1:0] lvl,
                     input bit [1:0] pls, input bit [1:0] rel, input int n);
    vec_t v;
    v.init = init; v.raw = raw; v.lvl = lvl; v.pls = pls; v.rel = rel;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endtask

  initial begin
    int cnt;
    int first;
    int hold [NB];
    int pe[$];
    int xe[$];
    int re;
    bit [4:0] bounce;

    initialise = 1'b1;
    btn_raw    = 2'b00;

    // reset with both held, pulse on the 6th edge after release
    add(1, 2'b11, 2'b00, 2'b00, 2'b00, 2);
    add(0, 2'b11, 2'b00, 2'b00, 2'b00, 5);
    add(0, 2'b11, 2'b11, 2'b11, 2'b00, 1);
    add(0, 2'b11, 2'b11, 2'b00, 2'b00, 2);
    // reset with no release pulse, then a 3-cycle glitch is rejected
    add(1, 2'b00, 2'b00, 2'b00, 2'b00, 1);
    add(0, 2'b01, 2'b00, 2'b00, 2'b00, 3);
    add(0, 2'b00, 2'b00, 2'b00, 2'b00, 8);
    // clean press then clean release of button 0
    add(0, 2'b01, 2'b00, 2'b00, 2'b00, 5);
    add(0, 2'b01, 2'b01, 2'b01, 2'b00, 1);
    add(0, 2'b01, 2'b01, 2'b00, 2'b00, 3);
    add(0, 2'b00, 2'b01, 2'b00, 2'b00, 5);
    add(0, 2'b00, 2'b00, 2'b00, 2'b01, 1);
    add(0, 2'b00, 2'b00, 2'b00, 2'b00, 2);

    for (int i = 0; i < tbl.size(); i++) begin
      initialise = tbl[i].init;
      btn_raw    = tbl[i].raw;
      step();
      check($sformatf("vec%0d", i), {btn_level, btn_pulse, btn_release},
            {tbl[i].lvl, tbl[i].pls, tbl[i].rel});
    end

    // bouncing press: exactly one pulse, DB+2 edges after the final rise
    initialise = 1'b1; btn_raw = 2'b00; step();
    initialise = 1'b0; step(); step();
    bounce = 5'b01101;
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      btn_raw[0] = bounce[k];
      step();
      if (btn_pulse[0]) cnt++;
    end
    check_int("bounce_no_early_pulse", cnt, 0);
    btn_raw[0] = 1'b1;
    cnt = 0; first = 0;
    for (int e = 1; e <= 14; e++) begin
      step();
      if (btn_pulse[0]) begin
        cnt++;
        if (first == 0) first = e;
      end
    end
    check_int("bounce_pulse_count", cnt, 1);
    check_int("bounce_pulse_edge", first, DB + 2);

    // reset in the middle of CHK_HI discards the partial count
    initialise = 1'b1; btn_raw = 2'b00; step();
    initialise = 1'b0; step();
    btn_raw = 2'b01;
    for (int k = 0; k < 4; k++) step();
    initialise = 1'b1; step();
    check("mid_chk_reset", {btn_level, btn_pulse, btn_release}, 6'b0);
    initialise = 1'b0;
    first = 0;
    for (int e = 1; e <= 20 && first == 0; e++) begin
      step();
      if (btn_pulse[0]) first = e;
    end
    check_int("repress_latency", first, DB + 2);

    // button 1 held for 30 cycles: press pulse, optional repeats, one release
    initialise = 1'b1; btn_raw = 2'b00; step();
    initialise = 1'b0; step();
    re = 0;
    for (int e = 1; e <= 50; e++) begin
      btn_raw = (e <= 30) ? 2'b10 : 2'b00;
      step();
      if (btn_pulse[1]) pe.push_back(e);
      if (btn_release[1]) re = e;
    end
    xe.push_back(DB + 2);
`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
    for (int e = DB + 2 + RD; e <= 32; e += RP) xe.push_back(e);
`endif
    check_int("hold_pulse_count", pe.size(), xe.size());
    for (int k = 0; k < xe.size(); k++)
      check_int($sformatf("hold_pulse%0d_edge", k), (k < pe.size()) ? pe[k] : -1, xe[k]);
    check_int("hold_release_edge", re, 31 + DB + 1);

    // randomized holds and occasional resets against the model
    for (int b = 0; b < NB; b++) hold[b] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < NB; b++) begin
        if (hold[b] == 0) begin
          btn_raw[b] = 1'($urandom_range(0, 1));
          hold[b] = $urandom_range(1, ($urandom_range(0, 3) == 0) ? 30 : 7);
        end
        hold[b]--;
      end
      initialise = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
